sccb_target_regfile: RTL and testbench
======================================

Name: sccb_target_regfile

Overview:
- SCCB/I2C target (responder) with a 256x8 register file; it emulates the OV7670 register interface at the far end of the camera configuration bus.
- Used in simulation and on-board loopback to check the SCCB initiator and its configuration table without a physical sensor.
- Oversamples SCL/SDA on the system clock, decodes 3-phase writes and 2-phase reads, and reports every register write on a strobe port.

Parameters:
- DEV_ADDR, 7'h21, 7-bit device address (write byte 0x42, read byte 0x43).
- RST_VAL, 8'h00, reset value of every register-file entry.
- AUTO_INC, 1, 1 = register pointer increments after each data byte (wraps 0xFF->0x00); 0 = pointer holds.

Ports:
- clk  in  1  system clock; must be at least 8x the SCL frequency.
- rst  in  1  synchronous active-high reset.
- scl_in  in  1  SCL pin level (asynchronous).
- sda_in  in  1  SDA pin level (asynchronous).
- sda_oe  out  1  1 = drive SDA low (open-drain); 0 = release.
- wr_stb  out  1  one-clk pulse per register written.
- wr_addr  out  8  register address of the write; valid while wr_stb=1.
- wr_data  out  8  data of the write; valid while wr_stb=1.
- busy  out  1  1 from START to STOP when the device address matched.
- dbg_addr  in  8  backdoor read address.
- dbg_data  out  8  combinational register-file read at dbg_addr.

Behaviour:
- Reset:
  - sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0.
  - Register pointer=0, state=IDLE, all entries=RST_VAL.
  - Reset mid-transfer aborts immediately, with SDA released in the same cycle.
- Input conditioning:
  - 2-FF synchronizer on SCL and SDA, plus one delay stage for edge detection.
  - Every pin event is acted on exactly 3 clk after the pin change.
- Bus conditions:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Data bits are sampled on SCL rising, MSB first; a bit counter runs 0..7, and the 9th clock is the ACK slot.
- START/STOP priority:
  - START in any state (repeated START included) clears the bit counter and goes to DEV; the pointer is kept.
  - STOP in any state goes to IDLE, releases SDA and clears busy.
- States:
  - IDLE: wait for START.
  - DEV: shift 8 bits.
    - Bits[7:1]==DEV_ADDR, R/W=0: busy=1, then ACK_DEV, then REG.
    - Bits[7:1]==DEV_ADDR, R/W=1: busy=1, then ACK_DEV, then RD.
    - Mismatch: IGNORE (no ACK, sda_oe held 0 until STOP/START).
  - REG: shift 8 bits, load the pointer, then ACK_REG, then WDAT.
  - WDAT: shift 8 bits.
    - Write mem[pointer]; pulse wr_stb with wr_addr=pointer, wr_data=byte, 1 clk after the 8th SCL-rise event.
    - Then ACK_DAT, then WDAT; the pointer increments after the strobe if AUTO_INC=1.
  - ACK_DEV / ACK_REG / ACK_DAT: sda_oe=1 from the SCL-fall that ends bit 8 until the SCL-fall that ends the ACK clock.
  - RD: load the shift register with mem[pointer].
    - Present each bit from SCL fall: sda_oe = ~bit (releasing gives 1).
    - The first bit is presented on the SCL fall after the device ACK.
    - After 8 bits, release SDA and go to MACK.
  - MACK: sample SDA on SCL rise.
    - 0 (ACK): increment the pointer if AUTO_INC, then RD.
    - 1 (NACK): go to IGNORE until STOP.
- Arithmetic: the pointer is 8 bits and wraps modulo 256.
- Simultaneous writes: a backdoor read of an address written in the same clk returns the old value.
- sda_oe changes only on a detected SCL-fall event, so it never changes while SCL is high, except on reset or STOP.

Test Plan:
- Write 0x42, 0x12, 0x14, STOP:
  - Three ACK pulses on sda_oe.
  - wr_stb once with wr_addr=0x12, wr_data=0x14; dbg_data at 0x12 = 0x14.
  - busy low after STOP.
- Read sequence: write phase 0x42, 0x0A, STOP; then 0x43; master NACK, STOP after preloading 0x0A=0x76:
  - SDA bit sequence reads 0x76.
  - sda_oe is 0 during the master NACK slot; no wr_stb.
- Wrong address 0x60, 0x12, 0x55:
  - sda_oe stays 0 throughout; no wr_stb; busy stays 0.
- AUTO_INC=1, write 0x42, 0xFF, 0xAA, 0xBB:
  - Strobes (0xFF, 0xAA) then (0x00, 0xBB).
- Repeated START mid-byte (after 4 bits of a data byte), then 0x42, 0x20, 0x01:
  - Partial byte discarded; only wr_stb (0x20, 0x01).
- rst asserted during the ACK slot of a register byte:
  - sda_oe=0 the next clk; state IDLE; entries = RST_VAL.
  - A following complete write is accepted normally.

Source files
------------

// File: rtl/sccb_target_regfile.sv
// sccb_target_regfile: SCCB/I2C target with a 256x8 register file emulating the OV7670 register map.
// Revision 1.0 - initial release.
`default_nettype none

module sccb_target_regfile #(
   parameter logic [6:0] DEV_ADDR = 7'h21,
   parameter logic [7:0] RST_VAL  = 8'h00,
   parameter int         AUTO_INC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_stb,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data
);

   typedef enum logic [3:0] {
      S_IDLE, S_DEV, S_REG, S_WDAT, S_RD, S_MACK,
      S_ACK_DEV, S_ACK_REG, S_ACK_DAT, S_IGNORE
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] ptr_q, ptr_d;
   logic       sda_oe_q, sda_oe_d;
   logic       busy_q, busy_d;
   logic       rw_q, rw_d;
   logic       wr_stb_q, wr_stb_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       mem_we;
   logic [7:0] mem_q [256];

   logic scl_s1_q, scl_s2_q, scl_d_q;
   logic sda_s1_q, sda_s2_q, sda_d_q;

   // Synchronizers reset to the idle-bus level so reset release creates no false START.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_d_q <= 1'b1;
         sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_d_q <= 1'b1;
      end else begin
         scl_s1_q <= scl_in; scl_s2_q <= scl_s1_q; scl_d_q <= scl_s2_q;
         sda_s1_q <= sda_in; sda_s2_q <= sda_s1_q; sda_d_q <= sda_s2_q;
      end
   end

   logic       scl_rise, scl_fall, start_ev, stop_ev;
   logic [7:0] byte_in, rd_byte;

   assign scl_rise = scl_s2_q & ~scl_d_q;
   assign scl_fall = ~scl_s2_q & scl_d_q;
   assign start_ev = scl_s2_q & scl_d_q & ~sda_s2_q & sda_d_q;
   assign stop_ev  = scl_s2_q & scl_d_q & sda_s2_q & ~sda_d_q;
   assign byte_in  = {shift_q[6:0], sda_s2_q};
   assign rd_byte  = mem_q[ptr_q];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      sda_oe_d  = sda_oe_q;
      busy_d    = busy_q;
      rw_d      = rw_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      mem_we    = 1'b0;

      if (stop_ev) begin
         state_d  = S_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
         cnt_d    = 4'd0;
      end else if (start_ev) begin
         state_d  = S_DEV;
         sda_oe_d = 1'b0;
         cnt_d    = 4'd0;
      end else begin
         case (state_q)
            S_DEV, S_REG, S_WDAT: begin
               if (scl_rise) begin
                  shift_d = byte_in;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d = 4'd0;
                     if (state_q == S_DEV) begin
                        if (byte_in[7:1] == DEV_ADDR) begin
                           busy_d  = 1'b1;
                           rw_d    = byte_in[0];
                           state_d = S_ACK_DEV;
                        end else begin
                           state_d = S_IGNORE;
                        end
                     end else if (state_q == S_REG) begin
                        ptr_d   = byte_in;
                        state_d = S_ACK_REG;
                     end else begin
                        mem_we    = 1'b1;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = byte_in;
                        if (AUTO_INC != 0) ptr_d = ptr_q + 8'd1;
                        state_d   = S_ACK_DAT;
                     end
                  end
               end
            end
            // First fall after the 8th bit asserts ACK; the next fall ends the ACK clock.
            S_ACK_DEV, S_ACK_REG, S_ACK_DAT: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     cnt_d    = 4'd0;
                     if (state_q == S_ACK_DEV && rw_q) begin
                        state_d  = S_RD;
                        shift_d  = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                     end else if (state_q == S_ACK_DEV) begin
                        state_d = S_REG;
                     end else begin
                        state_d = S_WDAT;
                     end
                  end
               end
            end
            S_RD: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     cnt_d    = 4'd0;
                     state_d  = S_MACK;
                  end else begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end
            // cnt_q = 1 marks an initiator ACK; the following fall starts the next byte.
            S_MACK: begin
               if (scl_rise) begin
                  if (sda_s2_q) begin
                     state_d = S_IGNORE;
                  end else begin
                     if (AUTO_INC != 0) ptr_d = ptr_q + 8'd1;
                     cnt_d = 4'd1;
                  end
               end else if (scl_fall && cnt_q == 4'd1) begin
                  shift_d  = rd_byte;
                  sda_oe_d = ~rd_byte[7];
                  cnt_d    = 4'd0;
                  state_d  = S_RD;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         shift_q   <= 8'd0;
         ptr_q     <= 8'd0;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         rw_q      <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= 8'd0;
         wr_data_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         ptr_q     <= ptr_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= busy_d;
         rw_q      <= rw_d;
         wr_stb_q  <= wr_stb_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem_q[i] <= RST_VAL;
      end else if (mem_we) begin
         mem_q[ptr_q] <= byte_in;
      end
   end

   assign sda_oe   = sda_oe_q;
   assign wr_stb   = wr_stb_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy     = busy_q;
   assign dbg_data = mem_q[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_sccb_target_regfile.sv
// tb_sccb_target_regfile: randomized SCCB initiator against a byte-level register-file model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_sccb_target_regfile;

   localparam int Q = 5;   // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic [7:0] dbg_addr = 8'd0;
   wire        sda_oe, wr_stb, busy;
   wire  [7:0] wr_addr, wr_data, dbg_data;
   wire        sda_line;

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   sccb_target_regfile dut (
      .clk      (clk),
      .rst      (rst),
      .scl_in   (scl_m),
      .sda_in   (sda_line),
      .sda_oe   (sda_oe),
      .wr_stb   (wr_stb),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  model_mem [256];
   logic [7:0]  model_ptr;
   logic [15:0] exp_q [$];
   logic [15:0] obs_q [$];
   logic [7:0]  dbuf [4];
   logic        watch = 1'b0;
   logic        oe_seen, busy_seen;

   always @(negedge clk) begin
      if (wr_stb) obs_q.push_back({wr_addr, wr_data});
      if (watch) begin
         if (sda_oe) oe_seen = 1'b1;
         if (busy) busy_seen = 1'b1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bus_start();
      if (!scl_m) begin
         sda_m = 1'b1; wait_q();
         scl_m = 1'b1; wait_q();
      end
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q(); wait_q();
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      ack = sda_line; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic read_byte(output logic [7:0] b, input logic nack);
      b = 8'd0;
      for (int i = 0; i < 8; i++) begin
         sda_m = 1'b1; wait_q();
         scl_m = 1'b1; wait_q();
         b = {b[6:0], sda_line}; wait_q();
         scl_m = 1'b0; wait_q();
      end
      sda_m = nack; wait_q();
      scl_m = 1'b1; wait_q();
      check_val("mack_slot_oe", sda_oe, 1'b0); wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic check_strobes();
      logic [15:0] e, o;
      repeat (4) @(negedge clk);
      check_val("stb_count", obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         check_val("stb_addr", o[15:8], e[15:8]);
         check_val("stb_data", o[7:0], e[7:0]);
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic check_mem(input logic [7:0] a);
      dbg_addr = a;
      @(negedge clk);
      check_val("dbg_data", dbg_data, model_mem[a]);
   endtask

   // Full write transaction: device byte, register byte, n data bytes from dbuf.
   task automatic do_write(input logic [7:0] regb, input int n);
      logic ack;
      bus_start();
      write_byte(8'h42, ack);
      check_val("wr_dev_ack", ack, 1'b0);
      check_val("busy_after_dev", busy, 1'b1);
      write_byte(regb, ack);
      check_val("wr_reg_ack", ack, 1'b0);
      model_ptr = regb;
      for (int i = 0; i < n; i++) begin
         write_byte(dbuf[i], ack);
         check_val("wr_dat_ack", ack, 1'b0);
         exp_q.push_back({model_ptr, dbuf[i]});
         model_mem[model_ptr] = dbuf[i];
         model_ptr = model_ptr + 8'd1;
      end
      bus_stop();
      check_val("busy_after_stop", busy, 1'b0);
      check_strobes();
   endtask

   // (Repeated) START, read address byte, n bytes with NACK on the last, STOP.
   task automatic do_read_cur(input int n);
      logic       ack;
      logic [7:0] b;
      bus_start();
      write_byte(8'h43, ack);
      check_val("rd_dev_ack", ack, 1'b0);
      for (int i = 0; i < n; i++) begin
         read_byte(b, (i == n - 1));
         check_val("rd_data", b, model_mem[model_ptr]);
         if (i != n - 1) model_ptr = model_ptr + 8'd1;
      end
      bus_stop();
      check_strobes();
   endtask

   task automatic do_wrong(input logic [6:0] a, input int n);
      logic ack;
      oe_seen = 1'b0; busy_seen = 1'b0; watch = 1'b1;
      bus_start();
      write_byte({a, 1'b0}, ack);
      check_val("wrong_dev_nak", ack, 1'b1);
      for (int i = 0; i < n; i++) begin
         write_byte(8'($urandom), ack);
         check_val("wrong_dat_nak", ack, 1'b1);
      end
      bus_stop();
      watch = 1'b0;
      check_val("wrong_oe_seen", oe_seen, 1'b0);
      check_val("wrong_busy_seen", busy_seen, 1'b0);
      check_strobes();
   endtask

   initial begin
      logic       ack;
      logic [7:0] regb;
      logic [6:0] wa;
      int         k;

      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
      model_ptr = 8'd0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_sda_oe", sda_oe, 1'b0);
      check_val("rst_wr_stb", wr_stb, 1'b0);
      check_val("rst_wr_addr", wr_addr, 8'h00);
      check_val("rst_wr_data", wr_data, 8'h00);
      check_val("rst_busy", busy, 1'b0);
      check_mem(8'h12);
      check_mem(8'hFF);
      repeat (10) @(negedge clk);

      // Basic write 0x12 <= 0x14.
      dbuf[0] = 8'h14;
      do_write(8'h12, 1);
      check_mem(8'h12);

      // Preload 0x0A, set the pointer with a write phase, then read with NACK.
      dbuf[0] = 8'h76;
      do_write(8'h0A, 1);
      do_write(8'h0A, 0);
      do_read_cur(1);

      // Wrong device address.
      do_wrong(7'h30, 2);

      // Pointer wrap across 0xFF.
      dbuf[0] = 8'hAA; dbuf[1] = 8'hBB;
      do_write(8'hFF, 2);
      check_mem(8'hFF);
      check_mem(8'h00);

      // Repeated START after half a data byte discards the partial byte.
      bus_start();
      write_byte(8'h42, ack);
      check_val("rs_dev_ack", ack, 1'b0);
      write_byte(8'h30, ack);
      check_val("rs_reg_ack", ack, 1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      dbuf[0] = 8'h01;
      do_write(8'h20, 1);
      check_mem(8'h30);
      check_mem(8'h20);

      // Reset during the register-byte ACK slot.
      bus_start();
      write_byte(8'h42, ack);
      check_val("ra_dev_ack", ack, 1'b0);
      for (int i = 7; i >= 0; i--) send_bit(regb_const(i));
      sda_m = 1'b1;
      k = 0;
      while (!sda_oe && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_val("ra_ack_driven", sda_oe, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_val("ra_oe_after_rst", sda_oe, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
      model_ptr = 8'd0;
      obs_q.delete();
      @(negedge clk);
      check_val("ra_busy", busy, 1'b0);
      check_mem(8'h12);
      check_mem(8'h20);
      scl_m = 1'b1; wait_q(); wait_q();
      dbuf[0] = 8'h99;
      do_write(8'h12, 1);
      check_mem(8'h12);

      // Randomized mix of writes, repeated-START reads and foreign-address traffic.
      for (int t = 0; t < 30; t++) begin
         regb = {($urandom_range(0, 1) != 0) ? 5'h1F : 5'h00, 3'($urandom_range(0, 7))};
         case ($urandom_range(0, 2))
            0: begin
               k = $urandom_range(1, 3);
               for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
               do_write(regb, k);
            end
            1: begin
               bus_start();
               write_byte(8'h42, ack);
               check_val("rr_dev_ack", ack, 1'b0);
               write_byte(regb, ack);
               check_val("rr_reg_ack", ack, 1'b0);
               model_ptr = regb;
               do_read_cur($urandom_range(1, 3));
            end
            default: begin
               wa = 7'($urandom_range(0, 127));
               if (wa == 7'h21) wa = 7'h22;
               do_wrong(wa, $urandom_range(0, 2));
            end
         endcase
      end

      for (int a = 0; a < 256; a++) check_mem(8'(a));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   function automatic logic regb_const(input int i);
      logic [7:0] r;
      r = 8'h12;
      return r[i];
   endfunction

endmodule

`default_nettype wire
